// File: rtl/pc_stack_sequencer_pkg.sv
// Shared types and constants for the return-address stack sequencer and its
// stack pointer. A frame is one 16-bit address stored as two bytes.
package pc_stack_sequencer_pkg;

    localparam int ADDR_W            = 16;
    localparam int FRAME_COUNT_W     = 7;
    localparam int STACK_FRAME_BYTES = 2;

    typedef logic [FRAME_COUNT_W-1:0] frame_count_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        POP_LO,
        POP_HI,
        FINISH
    } stack_state_t;

endpackage

// File: rtl/pc_stack_sequencer_stack_pointer.sv
// Byte stack pointer plus frame counter. The stack grows downward; sp always
// points at the next free byte, so the newest frame sits at sp+1 (low) and sp+2 (high).
module pc_stack_sequencer_stack_pointer
    import pc_stack_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP  = 16'hFFFF,
    parameter int                MAX_FRAMES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_commit,
    input  logic                     pop_commit,
    output logic [ADDR_W-1:0]        sp,
    output logic [ADDR_W-1:0]        sp_minus1,
    output logic [ADDR_W-1:0]        sp_plus1,
    output logic [ADDR_W-1:0]        sp_plus2,
    output logic [FRAME_COUNT_W-1:0] depth,
    output logic                     full,
    output logic                     empty
);

    localparam logic [ADDR_W-1:0] FRAME_STEP  = ADDR_W'(STACK_FRAME_BYTES);
    localparam frame_count_t      FRAME_LIMIT = FRAME_COUNT_W'(MAX_FRAMES);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;
    frame_count_t      depth_q;
    frame_count_t      depth_d;

    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        if (push_commit) begin
            sp_d    = sp_q - FRAME_STEP;
            depth_d = depth_q + 1'b1;
        end else if (pop_commit) begin
            sp_d    = sp_q + FRAME_STEP;
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= STACK_TOP;
            depth_q <= '0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

    // Address arithmetic wraps modulo 2^16; only the frame count decides faults.
    assign sp        = sp_q;
    assign sp_minus1 = sp_q - 16'd1;
    assign sp_plus1  = sp_q + 16'd1;
    assign sp_plus2  = sp_q + FRAME_STEP;
    assign depth     = depth_q;
    assign full      = (depth_q >= FRAME_LIMIT);
    assign empty     = (depth_q == '0);

endmodule

// File: rtl/pc_stack_sequencer.sv
// Control FSM pushing/popping 16-bit return addresses as byte pairs through
// cache_unit (loader_select steers its byte muxes) and the data-memory port.
module pc_stack_sequencer
    import pc_stack_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP  = 16'hFFFF,
    parameter int                MAX_FRAMES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_push,
    input  logic                     start_pop,
    input  logic                     mem_ready,
    output logic                     loader_select,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic                     pc_load,
    output logic                     hold_cache,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [FRAME_COUNT_W-1:0] depth
);

    stack_state_t      state_q;
    stack_state_t      state_d;
    logic              fault_q;
    logic              fault_d;
    logic              push_commit;
    logic              pop_commit;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_minus1;
    logic [ADDR_W-1:0] sp_plus1;
    logic [ADDR_W-1:0] sp_plus2;
    logic              full;
    logic              empty;

    pc_stack_sequencer_stack_pointer #(
        .STACK_TOP  (STACK_TOP),
        .MAX_FRAMES (MAX_FRAMES)
    ) u_stack_pointer (
        .clk         (clk),
        .reset       (reset),
        .push_commit (push_commit),
        .pop_commit  (pop_commit),
        .sp          (sp),
        .sp_minus1   (sp_minus1),
        .sp_plus1    (sp_plus1),
        .sp_plus2    (sp_plus2),
        .depth       (depth),
        .full        (full),
        .empty       (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fault_d       = 1'b0;
        loader_select = 1'b0;
        mem_addr      = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        pc_load       = 1'b0;
        done          = 1'b0;
        push_commit   = 1'b0;
        pop_commit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Push has priority; a simultaneous pop request is dropped.
                if (start_push) begin
                    if (full) fault_d = 1'b1;
                    else      state_d = PUSH_HI;
                end else if (start_pop) begin
                    if (empty) fault_d = 1'b1;
                    else       state_d = POP_LO;
                end
            end
            PUSH_HI: begin
                mem_addr  = sp;
                mem_write = 1'b1;
                if (mem_ready) state_d = PUSH_LO;
            end
            PUSH_LO: begin
                mem_addr      = sp_minus1;
                mem_write     = 1'b1;
                loader_select = 1'b1;
                if (mem_ready) begin
                    push_commit = 1'b1;
                    state_d     = FINISH;
                end
            end
            POP_LO: begin
                mem_addr = sp_plus1;
                mem_read = 1'b1;
                if (mem_ready) state_d = POP_HI;
            end
            POP_HI: begin
                // loader_select=1 freezes the latched low byte while the high byte arrives.
                mem_addr      = sp_plus2;
                mem_read      = 1'b1;
                loader_select = 1'b1;
                pc_load       = mem_ready & ~reset;
                if (mem_ready) begin
                    pop_commit = 1'b1;
                    state_d    = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign hold_cache = busy;
    assign fault      = fault_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench: sequencer + behavioural cache_unit byte muxes + byte memory, checked
// against a queue-based stack model with random stalls and operations.
module tb_pc_stack_sequencer;

    localparam logic [15:0] STACK_TOP  = 16'hFFFF;
    localparam int          MAX_FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_push;
    logic        start_pop;
    logic        mem_ready;
    logic        loader_select;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic        mem_read;
    logic        pc_load;
    logic        hold_cache;
    logic        busy;
    logic        done;
    logic        fault;
    logic [6:0]  depth;

    int checks   = 0;
    int failures = 0;

    // cache_unit model: pc upper byte / cached lower byte out, latched byte in
    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [7:0]  cached_lower;
    logic [7:0]  upper_latch;
    logic [7:0]  save_out;
    logic [7:0]  mem_out;
    logic [15:0] load_out;

    assign mem_out  = mem[mem_addr];
    assign save_out = loader_select ? cached_lower : pc[15:8];
    assign load_out = {mem_out, upper_latch};

    always @(posedge clk) begin
        if (mem_write && mem_ready) mem[mem_addr] <= save_out;
        if (!loader_select) upper_latch <= mem_out;
    end

    always #5 clk = ~clk;

    pc_stack_sequencer #(
        .STACK_TOP  (STACK_TOP),
        .MAX_FRAMES (MAX_FRAMES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_push    (start_push),
        .start_pop     (start_pop),
        .mem_ready     (mem_ready),
        .loader_select (loader_select),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .pc_load       (pc_load),
        .hold_cache    (hold_cache),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .depth         (depth)
    );

    // reference stack: each entry is the 16-bit address that was pushed
    logic [15:0] model_q [$];

    // observations of one operation
    int          obs_done_cyc, obs_fault_cyc, obs_fault_count;
    int          obs_pl_cyc, obs_pl_count, obs_nacc, obs_reads, obs_writes;
    logic [15:0] obs_pl_val;
    logic [15:0] obs_addr [4];
    logic        obs_ls [4];
    bit          obs_unstable, obs_both;

    // Issue one start (at a negedge), run until done or return to idle.
    // stall_acc selects which access (1 or 2) sees stall_n cycles of mem_ready=0.
    task automatic run_op(input bit p, input bit q, input int stall_acc,
                          input int stall_n, input bit busy_pop);
        int          acc;
        int          stalled;
        bit          in_acc;
        logic [15:0] a0;
        logic        w0, r0, l0;
        obs_done_cyc = 0; obs_fault_cyc = 0; obs_fault_count = 0;
        obs_pl_cyc = 0; obs_pl_count = 0; obs_nacc = 0; obs_reads = 0; obs_writes = 0;
        obs_pl_val = '0; obs_unstable = 0; obs_both = 0;
        for (int i = 0; i < 4; i++) begin
            obs_addr[i] = '0;
            obs_ls[i]   = 1'b0;
        end
        acc = 0; stalled = 0; in_acc = 0; a0 = '0; w0 = 0; r0 = 0; l0 = 0;
        start_push = p; start_pop = q; mem_ready = 1'b1;
        @(negedge clk);
        start_push = 1'b0; start_pop = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy_pop) start_pop = (cyc == 1);
            if (fault) begin
                obs_fault_count++;
                if (obs_fault_cyc == 0) obs_fault_cyc = cyc;
            end
            if (mem_write && mem_read) obs_both = 1;
            if (mem_write || mem_read) begin
                if (!in_acc) begin
                    if (acc < 4) begin
                        obs_addr[acc] = mem_addr;
                        obs_ls[acc]   = loader_select;
                    end
                    if (mem_write) obs_writes++;
                    if (mem_read)  obs_reads++;
                    a0 = mem_addr; w0 = mem_write; r0 = mem_read; l0 = loader_select;
                    in_acc = 1; stalled = 0;
                end else if (mem_addr !== a0 || mem_write !== w0 ||
                             mem_read !== r0 || loader_select !== l0) begin
                    obs_unstable = 1;
                end
                if (acc + 1 == stall_acc && stalled < stall_n) begin
                    mem_ready = 1'b0;
                    stalled++;
                end else begin
                    mem_ready = 1'b1;
                    in_acc = 0;
                    acc++;
                end
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (pc_load) begin
                obs_pl_count++;
                obs_pl_cyc = cyc;
                obs_pl_val = load_out;
            end
            if (done) obs_done_cyc = cyc;
            obs_nacc = acc;
            if (done || (!busy && cyc >= 2)) break;
            @(negedge clk);
        end
        start_pop = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        $display("op push=%0b pop=%0b accesses=%0d done_cyc=%0d pc_load_cyc=%0d load=%h fault_cyc=%0d depth=%0d",
                 p, q, obs_nacc, obs_done_cyc, obs_pl_cyc, obs_pl_val, obs_fault_cyc, depth);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_push = 1'b0; start_pop = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({loader_select, mem_write, mem_read, pc_load, hold_cache, busy, done, fault} !== 8'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=00000000",
                     {loader_select, mem_write, mem_read, pc_load, hold_cache, busy, done, fault});
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr);
        end
        checks++;
        if (depth !== 7'd0) begin
            failures++; $display("FAIL reset_depth got=%0d exp=0", depth);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b fault=%b exp=0 0", busy, fault);
        end
        model_q.delete();
        $display("op reset depth=%0d", depth);
    endtask

    task automatic test_push_basic();
        pc = 16'h1234; cached_lower = 8'h34;
        run_op(1, 0, 0, 0, 0);
        model_q.push_back(16'h1234);
        checks++;
        if (obs_done_cyc !== 3) begin
            failures++; $display("FAIL push_done_cycle got=%0d exp=3", obs_done_cyc);
        end
        checks++;
        if (obs_addr[0] !== 16'hFFFF || obs_addr[1] !== 16'hFFFE) begin
            failures++; $display("FAIL push_addrs got=%h,%h exp=ffff,fffe", obs_addr[0], obs_addr[1]);
        end
        checks++;
        if (obs_ls[0] !== 1'b0 || obs_ls[1] !== 1'b1) begin
            failures++; $display("FAIL push_loader_select got=%b%b exp=01", obs_ls[0], obs_ls[1]);
        end
        checks++;
        if (obs_writes !== 2 || obs_reads !== 0 || obs_both) begin
            failures++; $display("FAIL push_strobes writes=%0d reads=%0d exp=2 0", obs_writes, obs_reads);
        end
        checks++;
        if (mem[16'hFFFF] !== 8'h12 || mem[16'hFFFE] !== 8'h34) begin
            failures++; $display("FAIL push_mem got=%h%h exp=1234", mem[16'hFFFF], mem[16'hFFFE]);
        end
        checks++;
        if (depth !== 7'd1) begin
            failures++; $display("FAIL push_depth got=%0d exp=1", depth);
        end
    endtask

    task automatic test_pop_basic();
        pc = 16'h0000; cached_lower = 8'h00;
        run_op(0, 1, 0, 0, 0);
        void'(model_q.pop_back());
        checks++;
        if (obs_pl_count !== 1 || obs_pl_cyc !== 2) begin
            failures++; $display("FAIL pop_pc_load count=%0d cyc=%0d exp=1 2", obs_pl_count, obs_pl_cyc);
        end
        checks++;
        if (obs_pl_val !== 16'h1234) begin
            failures++; $display("FAIL pop_load_out got=%h exp=1234", obs_pl_val);
        end
        checks++;
        if (obs_done_cyc !== 3) begin
            failures++; $display("FAIL pop_done_cycle got=%0d exp=3", obs_done_cyc);
        end
        checks++;
        if (obs_addr[0] !== 16'hFFFE || obs_addr[1] !== 16'hFFFF || obs_reads !== 2 || obs_writes !== 0) begin
            failures++;
            $display("FAIL pop_accesses got=%h,%h r=%0d w=%0d exp=fffe,ffff r=2 w=0",
                     obs_addr[0], obs_addr[1], obs_reads, obs_writes);
        end
        checks++;
        if (depth !== 7'd0) begin
            failures++; $display("FAIL pop_depth got=%0d exp=0", depth);
        end
    endtask

    task automatic test_underflow();
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_fault_cyc !== 1 || obs_fault_count !== 1) begin
            failures++;
            $display("FAIL underflow_fault cyc=%0d count=%0d exp=1 1", obs_fault_cyc, obs_fault_count);
        end
        checks++;
        if (obs_nacc !== 0 || obs_done_cyc !== 0 || depth !== 7'd0) begin
            failures++;
            $display("FAIL underflow_no_access acc=%0d done=%0d depth=%0d exp=0 0 0",
                     obs_nacc, obs_done_cyc, depth);
        end
    endtask

    task automatic test_overflow();
        pc = 16'h4455; cached_lower = 8'h55;
        run_op(1, 0, 0, 0, 0);
        model_q.push_back(16'h4455);
        checks++;
        if (obs_addr[0] !== 16'hFFFF) begin
            failures++; $display("FAIL overflow_sp_restored got=%h exp=ffff", obs_addr[0]);
        end
        pc = 16'h6677; cached_lower = 8'h77;
        run_op(1, 0, 0, 0, 0);
        model_q.push_back(16'h6677);
        pc = 16'h8899; cached_lower = 8'h99;
        run_op(1, 0, 0, 0, 0);
        checks++;
        if (obs_fault_cyc !== 1 || obs_writes !== 0) begin
            failures++; $display("FAIL overflow_fault cyc=%0d writes=%0d exp=1 0", obs_fault_cyc, obs_writes);
        end
        checks++;
        if (depth !== 7'd2) begin
            failures++; $display("FAIL overflow_depth got=%0d exp=2", depth);
        end
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_addr[0] !== 16'hFFFC || obs_pl_val !== model_q.pop_back()) begin
            failures++; $display("FAIL overflow_pop1 addr=%h load=%h exp=fffc 6677", obs_addr[0], obs_pl_val);
        end
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_pl_val !== model_q.pop_back() || depth !== 7'd0) begin
            failures++; $display("FAIL overflow_pop2 load=%h depth=%0d exp=4455 0", obs_pl_val, depth);
        end
    endtask

    task automatic test_wait_states();
        pc = 16'h1234; cached_lower = 8'h34;
        run_op(1, 0, 2, 3, 0);
        model_q.push_back(16'h1234);
        checks++;
        if (obs_unstable || obs_done_cyc !== 6) begin
            failures++; $display("FAIL wait_push unstable=%b done=%0d exp=0 6", obs_unstable, obs_done_cyc);
        end
        checks++;
        if (mem[16'hFFFF] !== 8'h12 || mem[16'hFFFE] !== 8'h34 || depth !== 7'd1) begin
            failures++;
            $display("FAIL wait_push_mem got=%h%h depth=%0d exp=1234 1", mem[16'hFFFF], mem[16'hFFFE], depth);
        end
        pc = 16'h0000; cached_lower = 8'h00;
        run_op(0, 1, 1, 3, 0);
        void'(model_q.pop_back());
        checks++;
        if (obs_unstable || obs_pl_count !== 1 || obs_pl_cyc !== 5 || obs_done_cyc !== 6) begin
            failures++;
            $display("FAIL wait_pop unstable=%b pl_count=%0d pl_cyc=%0d done=%0d exp=0 1 5 6",
                     obs_unstable, obs_pl_count, obs_pl_cyc, obs_done_cyc);
        end
        checks++;
        if (obs_pl_val !== 16'h1234) begin
            failures++; $display("FAIL wait_pop_load got=%h exp=1234", obs_pl_val);
        end
    endtask

    task automatic test_back_to_back();
        pc = 16'hA1B2; cached_lower = 8'hB2;
        run_op(1, 1, 0, 0, 0);
        model_q.push_back(16'hA1B2);
        checks++;
        if (obs_writes !== 2 || obs_reads !== 0 || depth !== 7'd1) begin
            failures++;
            $display("FAIL both_starts writes=%0d reads=%0d depth=%0d exp=2 0 1", obs_writes, obs_reads, depth);
        end
        pc = 16'hC3D4; cached_lower = 8'hD4;
        run_op(1, 0, 0, 0, 1);
        model_q.push_back(16'hC3D4);
        checks++;
        if (obs_writes !== 2 || obs_reads !== 0 || depth !== 7'd2) begin
            failures++;
            $display("FAIL busy_pop_ignored writes=%0d reads=%0d depth=%0d exp=2 0 2", obs_writes, obs_reads, depth);
        end
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_pl_val !== model_q.pop_back()) begin
            failures++; $display("FAIL b2b_pop1 got=%h exp=c3d4", obs_pl_val);
        end
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_pl_val !== model_q.pop_back() || depth !== 7'd0) begin
            failures++; $display("FAIL b2b_pop2 got=%h depth=%0d exp=a1b2 0", obs_pl_val, depth);
        end
    endtask

    task automatic test_reset_mid_pop();
        bit seen_pl;
        pc = 16'hBEEF; cached_lower = 8'hEF;
        run_op(1, 0, 0, 0, 0);
        mem_ready = 1'b1; start_pop = 1'b1;
        @(negedge clk);
        start_pop = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || loader_select !== 1'b1) begin
            failures++; $display("FAIL rst_reach_pop_hi read=%b ls=%b exp=1 1", mem_read, loader_select);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pc_load !== 1'b0) begin
            failures++; $display("FAIL rst_pc_load got=%b exp=0", pc_load);
        end
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        checks++;
        if ({loader_select, mem_write, mem_read, pc_load, hold_cache, busy, done, fault} !== 8'b0 ||
            mem_addr !== 16'h0000 || depth !== 7'd0) begin
            failures++;
            $display("FAIL rst_mid_state strobes=%b addr=%h depth=%0d exp=00000000 0000 0",
                     {loader_select, mem_write, mem_read, pc_load, hold_cache, busy, done, fault},
                     mem_addr, depth);
        end
        seen_pl = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pc_load || done || busy) seen_pl = 1;
        end
        checks++;
        if (seen_pl) begin
            failures++; $display("FAIL rst_quiet got=activity exp=idle");
        end
        pc = 16'h5AA5; cached_lower = 8'hA5;
        run_op(1, 0, 0, 0, 0);
        checks++;
        if (obs_addr[0] !== STACK_TOP) begin
            failures++; $display("FAIL rst_sp got=%h exp=%h", obs_addr[0], STACK_TOP);
        end
        run_op(0, 1, 0, 0, 0);
        checks++;
        if (obs_pl_val !== 16'h5AA5 || depth !== 7'd0) begin
            failures++; $display("FAIL rst_pop got=%h depth=%0d exp=5aa5 0", obs_pl_val, depth);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          kind, s_acc, s_n, sz;
            bit          p, q;
            logic [15:0] sp_exp, exp_val, a_lo, a_hi;
            kind  = $urandom_range(0, 4);
            p     = (kind < 2) || (kind == 4);
            q     = (kind >= 2);
            s_acc = $urandom_range(1, 2);
            s_n   = $urandom_range(0, 3);
            pc           = 16'($urandom);
            cached_lower = 8'($urandom);
            sz     = model_q.size();
            sp_exp = STACK_TOP - 16'(2 * sz);
            run_op(p, q, s_acc, s_n, 0);
            if (p) begin
                if (sz >= MAX_FRAMES) begin
                    checks++;
                    if (obs_fault_cyc !== 1 || obs_nacc !== 0) begin
                        failures++;
                        $display("FAIL rand_push_full fault_cyc=%0d acc=%0d exp=1 0", obs_fault_cyc, obs_nacc);
                    end
                end else begin
                    exp_val = {pc[15:8], cached_lower};
                    model_q.push_back(exp_val);
                    a_hi = sp_exp;
                    a_lo = sp_exp - 16'd1;
                    checks++;
                    if (obs_writes !== 2 || obs_reads !== 0 || obs_addr[0] !== a_hi || obs_addr[1] !== a_lo) begin
                        failures++;
                        $display("FAIL rand_push_access w=%0d r=%0d addrs=%h,%h exp=2 0 %h,%h",
                                 obs_writes, obs_reads, obs_addr[0], obs_addr[1], a_hi, a_lo);
                    end
                    checks++;
                    if ({mem[a_hi], mem[a_lo]} !== exp_val) begin
                        failures++; $display("FAIL rand_push_mem got=%h%h exp=%h", mem[a_hi], mem[a_lo], exp_val);
                    end
                    checks++;
                    if (obs_done_cyc !== 3 + s_n || obs_fault_count !== 0) begin
                        failures++;
                        $display("FAIL rand_push_timing done=%0d faults=%0d exp=%0d 0",
                                 obs_done_cyc, obs_fault_count, 3 + s_n);
                    end
                end
            end else begin
                if (sz == 0) begin
                    checks++;
                    if (obs_fault_cyc !== 1 || obs_nacc !== 0) begin
                        failures++;
                        $display("FAIL rand_pop_empty fault_cyc=%0d acc=%0d exp=1 0", obs_fault_cyc, obs_nacc);
                    end
                end else begin
                    exp_val = model_q.pop_back();
                    checks++;
                    if (obs_reads !== 2 || obs_writes !== 0 ||
                        obs_addr[0] !== sp_exp + 16'd1 || obs_addr[1] !== sp_exp + 16'd2) begin
                        failures++;
                        $display("FAIL rand_pop_access r=%0d w=%0d addrs=%h,%h exp=2 0 %h,%h",
                                 obs_reads, obs_writes, obs_addr[0], obs_addr[1],
                                 sp_exp + 16'd1, sp_exp + 16'd2);
                    end
                    checks++;
                    if (obs_pl_count !== 1 || obs_pl_val !== exp_val) begin
                        failures++;
                        $display("FAIL rand_pop_value count=%0d got=%h exp=1 %h", obs_pl_count, obs_pl_val, exp_val);
                    end
                    checks++;
                    if (obs_pl_cyc !== 2 + s_n || obs_done_cyc !== 3 + s_n) begin
                        failures++;
                        $display("FAIL rand_pop_timing pl=%0d done=%0d exp=%0d %0d",
                                 obs_pl_cyc, obs_done_cyc, 2 + s_n, 3 + s_n);
                    end
                end
            end
            checks++;
            if (depth !== 7'(model_q.size())) begin
                failures++; $display("FAIL rand_depth got=%0d exp=%0d", depth, model_q.size());
            end
            checks++;
            if (obs_both || obs_unstable) begin
                failures++; $display("FAIL rand_strobes both=%b unstable=%b exp=0 0", obs_both, obs_unstable);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start_push = 1'b0; start_pop = 1'b0; mem_ready = 1'b1;
        pc = '0; cached_lower = '0;
        test_reset();
        test_push_basic();
        test_pop_basic();
        test_underflow();
        test_overflow();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
